// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI-Lite read or
// write and returns the captured response. Every interface output comes from a register.
module axil_master #(
   parameter int G_AXIL_ADDR_W = 8,
   parameter int G_AXIL_DATA_W = 64
) (
   input  logic                         i_clk,
   input  logic                         i_rst,

   input  logic                         i_cmd_valid,
   output logic                         o_cmd_ready,
   input  logic                         i_cmd_wr,
   input  logic [G_AXIL_ADDR_W-1:0]     i_cmd_addr,
   input  logic [G_AXIL_DATA_W-1:0]     i_cmd_wdata,
   input  logic [G_AXIL_DATA_W/8-1:0]   i_cmd_wstrb,

   output logic                         o_rsp_valid,
   input  logic                         i_rsp_ready,
   output logic [G_AXIL_DATA_W-1:0]     o_rsp_rdata,
   output logic [1:0]                   o_rsp_resp,

   output logic                         m_axil_awvalid,
   input  logic                         m_axil_awready,
   output logic [G_AXIL_ADDR_W-1:0]     m_axil_awaddr,
   output logic [2:0]                   m_axil_awprot,
   output logic                         m_axil_wvalid,
   input  logic                         m_axil_wready,
   output logic [G_AXIL_DATA_W-1:0]     m_axil_wdata,
   output logic [G_AXIL_DATA_W/8-1:0]   m_axil_wstrb,
   input  logic                         m_axil_bvalid,
   output logic                         m_axil_bready,
   input  logic [1:0]                   m_axil_bresp,

   output logic                         m_axil_arvalid,
   input  logic                         m_axil_arready,
   output logic [G_AXIL_ADDR_W-1:0]     m_axil_araddr,
   output logic [2:0]                   m_axil_arprot,
   input  logic                         m_axil_rvalid,
   output logic                         m_axil_rready,
   input  logic [G_AXIL_DATA_W-1:0]     m_axil_rdata,
   input  logic [1:0]                   m_axil_rresp
);

   localparam int STRB_W = G_AXIL_DATA_W / 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WADDR,
      ST_RADDR,
      ST_WRESP,
      ST_RDATA,
      ST_RSP
   } state_t;

   state_t                     state, state_n;
   logic                       cmd_ready_q, cmd_ready_n;
   logic                       awvalid_q, awvalid_n;
   logic                       wvalid_q, wvalid_n;
   logic                       bready_q, bready_n;
   logic                       arvalid_q, arvalid_n;
   logic                       rready_q, rready_n;
   logic                       rsp_valid_q, rsp_valid_n;
   logic [G_AXIL_ADDR_W-1:0]   addr_q, addr_n;
   logic [G_AXIL_DATA_W-1:0]   wdata_q, wdata_n;
   logic [STRB_W-1:0]          wstrb_q, wstrb_n;
   logic [G_AXIL_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_n;
   logic [1:0]                 rsp_resp_q, rsp_resp_n;
   logic                       aw_pending;
   logic                       w_pending;

   // A channel is still pending while its valid is up and the slave has not taken it
   assign aw_pending = awvalid_q && !m_axil_awready;
   assign w_pending  = wvalid_q  && !m_axil_wready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         cmd_ready_q <= 1'b1;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
      end else begin
         state       <= state_n;
         cmd_ready_q <= cmd_ready_n;
         awvalid_q   <= awvalid_n;
         wvalid_q    <= wvalid_n;
         bready_q    <= bready_n;
         arvalid_q   <= arvalid_n;
         rready_q    <= rready_n;
         rsp_valid_q <= rsp_valid_n;
         addr_q      <= addr_n;
         wdata_q     <= wdata_n;
         wstrb_q     <= wstrb_n;
         rsp_rdata_q <= rsp_rdata_n;
         rsp_resp_q  <= rsp_resp_n;
      end
   end

   always_comb begin
      state_n     = state;
      cmd_ready_n = cmd_ready_q;
      awvalid_n   = awvalid_q;
      wvalid_n    = wvalid_q;
      bready_n    = bready_q;
      arvalid_n   = arvalid_q;
      rready_n    = rready_q;
      rsp_valid_n = rsp_valid_q;
      addr_n      = addr_q;
      wdata_n     = wdata_q;
      wstrb_n     = wstrb_q;
      rsp_rdata_n = rsp_rdata_q;
      rsp_resp_n  = rsp_resp_q;

      case (state)
         ST_IDLE: begin
            if (i_cmd_valid && cmd_ready_q) begin
               cmd_ready_n = 1'b0;
               addr_n      = i_cmd_addr;
               wdata_n     = i_cmd_wdata;
               wstrb_n     = i_cmd_wstrb;
               if (i_cmd_wr) begin
                  state_n   = ST_WADDR;
                  awvalid_n = 1'b1;
                  wvalid_n  = 1'b1;
               end else begin
                  state_n   = ST_RADDR;
                  arvalid_n = 1'b1;
               end
            end
         end

         // AW and W retire independently; B is only opened once both are gone
         ST_WADDR: begin
            awvalid_n = aw_pending;
            wvalid_n  = w_pending;
            if (!aw_pending && !w_pending) begin
               state_n  = ST_WRESP;
               bready_n = 1'b1;
            end
         end

         ST_WRESP: begin
            if (m_axil_bvalid) begin
               state_n     = ST_RSP;
               bready_n    = 1'b0;
               rsp_valid_n = 1'b1;
               rsp_rdata_n = '0;
               rsp_resp_n  = m_axil_bresp;
            end
         end

         ST_RADDR: begin
            if (m_axil_arready) begin
               state_n   = ST_RDATA;
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
            end
         end

         ST_RDATA: begin
            if (m_axil_rvalid) begin
               state_n     = ST_RSP;
               rready_n    = 1'b0;
               rsp_valid_n = 1'b1;
               rsp_rdata_n = m_axil_rdata;
               rsp_resp_n  = m_axil_rresp;
            end
         end

         ST_RSP: begin
            if (i_rsp_ready) begin
               state_n     = ST_IDLE;
               rsp_valid_n = 1'b0;
               cmd_ready_n = 1'b1;
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   assign o_cmd_ready    = cmd_ready_q;
   assign o_rsp_valid    = rsp_valid_q;
   assign o_rsp_rdata    = rsp_rdata_q;
   assign o_rsp_resp     = rsp_resp_q;

   assign m_axil_awvalid = awvalid_q;
   assign m_axil_awaddr  = addr_q;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_wvalid  = wvalid_q;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = wstrb_q;
   assign m_axil_bready  = bready_q;

   assign m_axil_arvalid = arvalid_q;
   assign m_axil_araddr  = addr_q;
   assign m_axil_arprot  = 3'b000;
   assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: a configurable AXI-Lite slave model answers the
// master, and a scoreboard monitor compares every returned response with a queue.
module tb_axil_master;

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  resp;
   } rsp_t;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_cmd_valid, o_cmd_ready, i_cmd_wr;
   logic [7:0]  i_cmd_addr;
   logic [63:0] i_cmd_wdata;
   logic [7:0]  i_cmd_wstrb;
   logic        o_rsp_valid, i_rsp_ready;
   logic [63:0] o_rsp_rdata;
   logic [1:0]  o_rsp_resp;
   logic        m_axil_awvalid, m_axil_awready;
   logic [7:0]  m_axil_awaddr;
   logic [2:0]  m_axil_awprot;
   logic        m_axil_wvalid, m_axil_wready;
   logic [63:0] m_axil_wdata;
   logic [7:0]  m_axil_wstrb;
   logic        m_axil_bvalid, m_axil_bready;
   logic [1:0]  m_axil_bresp;
   logic        m_axil_arvalid, m_axil_arready;
   logic [7:0]  m_axil_araddr;
   logic [2:0]  m_axil_arprot;
   logic        m_axil_rvalid, m_axil_rready;
   logic [63:0] m_axil_rdata;
   logic [1:0]  m_axil_rresp;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // slave behaviour settings and expectations, written only by the main stimulus block
   int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
   logic        b_early = 1'b0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [63:0] rdata_cfg = '0;
   logic [7:0]  exp_addr = '0, exp_wstrb = '0;
   logic [63:0] exp_wdata = '0;
   int          aborts = 0;
   int          acc_cyc = 0;

   int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, rsp_cnt = 0;
   int aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0, ar_hs_cyc = 0, r_hs_cyc = 0;
   int rsp_rise_cyc = 0;

   rsp_t exp_q[$];

   axil_master #(.G_AXIL_ADDR_W(8), .G_AXIL_DATA_W(64)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_cmd_valid    (i_cmd_valid),
      .o_cmd_ready    (o_cmd_ready),
      .i_cmd_wr       (i_cmd_wr),
      .i_cmd_addr     (i_cmd_addr),
      .i_cmd_wdata    (i_cmd_wdata),
      .i_cmd_wstrb    (i_cmd_wstrb),
      .o_rsp_valid    (o_rsp_valid),
      .i_rsp_ready    (i_rsp_ready),
      .o_rsp_rdata    (o_rsp_rdata),
      .o_rsp_resp     (o_rsp_resp),
      .m_axil_awvalid (m_axil_awvalid),
      .m_axil_awready (m_axil_awready),
      .m_axil_awaddr  (m_axil_awaddr),
      .m_axil_awprot  (m_axil_awprot),
      .m_axil_wvalid  (m_axil_wvalid),
      .m_axil_wready  (m_axil_wready),
      .m_axil_wdata   (m_axil_wdata),
      .m_axil_wstrb   (m_axil_wstrb),
      .m_axil_bvalid  (m_axil_bvalid),
      .m_axil_bready  (m_axil_bready),
      .m_axil_bresp   (m_axil_bresp),
      .m_axil_arvalid (m_axil_arvalid),
      .m_axil_arready (m_axil_arready),
      .m_axil_araddr  (m_axil_araddr),
      .m_axil_arprot  (m_axil_arprot),
      .m_axil_rvalid  (m_axil_rvalid),
      .m_axil_rready  (m_axil_rready),
      .m_axil_rdata   (m_axil_rdata),
      .m_axil_rresp   (m_axil_rresp)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, wanted %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checkOutput(name, {63'b0, act}, {63'b0, exp});
   endtask

   // Drives one command and returns once it has been accepted; acc_cyc is the accept cycle
   task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [63:0] wdata,
                                input logic [7:0] wstrb, input logic [63:0] exp_data,
                                input logic [1:0] exp_resp, input logic push);
      int n = 0;
      exp_addr  = addr;
      exp_wdata = wdata;
      exp_wstrb = wstrb;
      @(posedge i_clk); #1;
      i_cmd_valid = 1'b1;
      i_cmd_wr    = wr;
      i_cmd_addr  = addr;
      i_cmd_wdata = wdata;
      i_cmd_wstrb = wstrb;
      if (push) exp_q.push_back('{data: exp_data, resp: exp_resp});
      @(negedge i_clk);
      while (!o_cmd_ready && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_cmd_ready) checkBit("cmd_accept_timeout", o_cmd_ready, 1'b1);
      acc_cyc = cyc;
      @(posedge i_clk); #1;
      i_cmd_valid = 1'b0;
   endtask

   task automatic waitRsp(input int target);
      int n = 0;
      while (rsp_cnt < target && n < 300) begin
         @(negedge i_clk);
         n++;
      end
      if (rsp_cnt < target) checkOutput("rsp_timeout", 64'(rsp_cnt), 64'(target));
      @(negedge i_clk);
   endtask

   // AW channel of the slave model
   initial begin
      m_axil_awready = 1'b0;
      forever begin
         @(negedge i_clk);
         if (m_axil_awvalid) begin
            repeat (aw_wait) @(negedge i_clk);
            if (m_axil_awvalid) begin
               m_axil_awready = 1'b1;
               aw_hs_cyc = cyc;
               aw_cnt++;
               checkOutput("awaddr", {56'b0, m_axil_awaddr}, {56'b0, exp_addr});
               @(posedge i_clk); #1;
               m_axil_awready = 1'b0;
            end
         end
      end
   end

   initial begin
      m_axil_wready = 1'b0;
      forever begin
         @(negedge i_clk);
         if (m_axil_wvalid) begin
            repeat (w_wait) @(negedge i_clk);
            if (m_axil_wvalid) begin
               m_axil_wready = 1'b1;
               w_hs_cyc = cyc;
               w_cnt++;
               checkOutput("wdata", m_axil_wdata, exp_wdata);
               checkOutput("wstrb", {56'b0, m_axil_wstrb}, {56'b0, exp_wstrb});
               @(posedge i_clk); #1;
               m_axil_wready = 1'b0;
            end
         end
      end
   end

   // B channel: with b_early the slave raises bvalid while the address phase is still open
   initial begin
      int n;
      m_axil_bvalid = 1'b0;
      m_axil_bresp  = 2'b00;
      forever begin
         @(negedge i_clk);
         if (m_axil_bready || (b_early && (m_axil_awvalid || m_axil_wvalid))) begin
            if (!b_early) begin
               repeat (b_wait) @(negedge i_clk);
               if (!m_axil_bready) continue;
            end
            m_axil_bvalid = 1'b1;
            m_axil_bresp  = bresp_cfg;
            n = 0;
            while (!m_axil_bready && n < 50) begin
               @(negedge i_clk);
               n++;
            end
            if (m_axil_bready) begin
               b_hs_cyc = cyc;
               checkBit("b_after_aw_w", (aw_cnt == w_cnt) && (aw_cnt == b_cnt + aborts + 1), 1'b1);
               b_cnt++;
               @(posedge i_clk); #1;
            end
            m_axil_bvalid = 1'b0;
            m_axil_bresp  = 2'b00;
         end
      end
   end

   initial begin
      m_axil_arready = 1'b0;
      forever begin
         @(negedge i_clk);
         if (m_axil_arvalid) begin
            repeat (ar_wait) @(negedge i_clk);
            if (m_axil_arvalid) begin
               m_axil_arready = 1'b1;
               ar_hs_cyc = cyc;
               ar_cnt++;
               checkOutput("araddr", {56'b0, m_axil_araddr}, {56'b0, exp_addr});
               @(posedge i_clk); #1;
               m_axil_arready = 1'b0;
            end
         end
      end
   end

   initial begin
      m_axil_rvalid = 1'b0;
      m_axil_rdata  = '0;
      m_axil_rresp  = 2'b00;
      forever begin
         @(negedge i_clk);
         if (m_axil_rready) begin
            repeat (r_wait) @(negedge i_clk);
            if (!m_axil_rready) continue;
            m_axil_rvalid = 1'b1;
            m_axil_rdata  = rdata_cfg;
            m_axil_rresp  = rresp_cfg;
            r_hs_cyc = cyc;
            checkBit("r_after_ar", ar_cnt == r_cnt + 1, 1'b1);
            r_cnt++;
            @(posedge i_clk); #1;
            m_axil_rvalid = 1'b0;
            m_axil_rdata  = '0;
            m_axil_rresp  = 2'b00;
         end
      end
   end

   // Scoreboard monitor: pops one expectation per response handshake
   initial begin
      rsp_t e;
      logic prev = 1'b0;
      forever begin
         @(negedge i_clk);
         if (o_rsp_valid && !prev) rsp_rise_cyc = cyc;
         prev = o_rsp_valid;
         if (o_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) begin
               checkBit("rsp_unexpected", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("rsp_rdata", o_rsp_rdata, e.data);
               checkOutput("rsp_resp", {62'b0, o_rsp_resp}, {62'b0, e.resp});
            end
            rsp_cnt++;
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, wanted < 30000", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base, n, saved_aw, saved_ar;
      i_rst       = 1'b1;
      i_cmd_valid = 1'b0;
      i_cmd_wr    = 1'b0;
      i_cmd_addr  = '0;
      i_cmd_wdata = '0;
      i_cmd_wstrb = '0;
      i_rsp_ready = 1'b0;

      repeat (3) @(negedge i_clk);
      checkBit("rst_cmd_ready", o_cmd_ready, 1'b1);
      checkBit("rst_rsp_valid", o_rsp_valid, 1'b0);
      checkOutput("rst_valids", {59'b0, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                  m_axil_bready, m_axil_rready}, 64'd0);
      checkOutput("rst_awaddr", {56'b0, m_axil_awaddr}, 64'd0);
      checkOutput("rst_rsp_rdata", o_rsp_rdata, 64'd0);
      checkOutput("prot", {58'b0, m_axil_awprot, m_axil_arprot}, 64'd0);
      @(posedge i_clk); #1;
      i_rst       = 1'b0;
      i_rsp_ready = 1'b1;
      @(negedge i_clk);
      checkBit("post_rst_cmd_ready", o_cmd_ready, 1'b1);

      // zero-wait write
      base = rsp_cnt;
      applyStimulus(1'b1, 8'h10, 64'h1122334455667788, 8'hFF, 64'h0, 2'b00, 1'b1);
      waitRsp(base + 1);
      checkOutput("wr_aw_lat", 64'(aw_hs_cyc - acc_cyc), 64'd1);
      checkOutput("wr_w_lat", 64'(w_hs_cyc - acc_cyc), 64'd1);
      checkOutput("wr_b_lat", 64'(b_hs_cyc - acc_cyc), 64'd2);
      checkOutput("wr_rsp_lat", 64'(rsp_rise_cyc - acc_cyc), 64'd3);

      // read with five wait states on R and SLVERR
      r_wait = 5; rdata_cfg = 64'hDEADBEEF00000001; rresp_cfg = 2'b10;
      base = rsp_cnt;
      applyStimulus(1'b0, 8'h20, 64'h0, 8'h00, 64'hDEADBEEF00000001, 2'b10, 1'b1);
      waitRsp(base + 1);
      checkOutput("rd_ar_lat", 64'(ar_hs_cyc - acc_cyc), 64'd1);
      checkOutput("rd_r_lat", 64'(r_hs_cyc - acc_cyc), 64'd7);
      checkOutput("rd_rsp_lat", 64'(rsp_rise_cyc - acc_cyc), 64'd8);

      // W accepted three cycles before AW, with a premature bvalid from the slave
      aw_wait = 3; b_early = 1'b1; bresp_cfg = 2'b01;
      base = rsp_cnt;
      applyStimulus(1'b1, 8'h44, 64'hA5A5A5A55A5A5A5A, 8'h0F, 64'h0, 2'b01, 1'b1);
      @(negedge i_clk);
      @(negedge i_clk);
      checkBit("split_wvalid_dropped", m_axil_wvalid, 1'b0);
      checkBit("split_awvalid_held", m_axil_awvalid, 1'b1);
      checkBit("split_no_bready", m_axil_bready, 1'b0);
      @(negedge i_clk);
      checkBit("split_awvalid_held2", m_axil_awvalid, 1'b1);
      checkBit("split_no_bready2", m_axil_bready, 1'b0);
      waitRsp(base + 1);
      checkOutput("split_w_lat", 64'(w_hs_cyc - acc_cyc), 64'd1);
      checkOutput("split_aw_lat", 64'(aw_hs_cyc - acc_cyc), 64'd4);
      checkOutput("split_b_lat", 64'(b_hs_cyc - acc_cyc), 64'd5);
      checkOutput("split_rsp_lat", 64'(rsp_rise_cyc - acc_cyc), 64'd6);
      aw_wait = 0; b_early = 1'b0;

      // AW and W taken in the same cycle after two waits, top address, DECERR
      aw_wait = 2; w_wait = 2; bresp_cfg = 2'b11;
      base = rsp_cnt;
      applyStimulus(1'b1, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 8'h81, 64'h0, 2'b11, 1'b1);
      waitRsp(base + 1);
      checkOutput("same_aw_lat", 64'(aw_hs_cyc - acc_cyc), 64'd3);
      checkOutput("same_w_lat", 64'(w_hs_cyc - acc_cyc), 64'd3);
      checkOutput("same_rsp_lat", 64'(rsp_rise_cyc - acc_cyc), 64'd5);
      aw_wait = 0; w_wait = 0; bresp_cfg = 2'b00;

      // response back-pressure: data must hold and a new command must be ignored
      r_wait = 0; rdata_cfg = 64'h0F0E0D0C0B0A0908; rresp_cfg = 2'b00;
      i_rsp_ready = 1'b0;
      base = rsp_cnt;
      applyStimulus(1'b0, 8'h80, 64'h0, 8'h00, 64'h0F0E0D0C0B0A0908, 2'b00, 1'b1);
      n = 0;
      while (!o_rsp_valid && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      checkBit("bp_rsp_valid_seen", o_rsp_valid, 1'b1);
      saved_aw = aw_cnt;
      saved_ar = ar_cnt;
      @(posedge i_clk); #1;
      i_cmd_valid = 1'b1; i_cmd_wr = 1'b1; i_cmd_addr = 8'h55;
      repeat (4) begin
         @(negedge i_clk);
         checkBit("bp_rsp_valid", o_rsp_valid, 1'b1);
         checkOutput("bp_rsp_rdata", o_rsp_rdata, 64'h0F0E0D0C0B0A0908);
         checkOutput("bp_rsp_resp", {62'b0, o_rsp_resp}, 64'd0);
         checkBit("bp_cmd_ready", o_cmd_ready, 1'b0);
      end
      @(posedge i_clk); #1;
      i_cmd_valid = 1'b0; i_rsp_ready = 1'b1;
      waitRsp(base + 1);
      repeat (3) @(negedge i_clk);
      checkOutput("bp_no_extra_aw", 64'(aw_cnt), 64'(saved_aw));
      checkOutput("bp_no_extra_ar", 64'(ar_cnt), 64'(saved_ar));
      checkBit("bp_back_idle", o_cmd_ready, 1'b1);

      // reset while waiting for B: transaction is abandoned without a response
      b_wait = 10;
      base = rsp_cnt;
      applyStimulus(1'b1, 8'h3C, 64'h0102030405060708, 8'hFF, 64'h0, 2'b00, 1'b0);
      n = 0;
      while (!m_axil_bready && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      checkBit("rst_wresp_reached", m_axil_bready, 1'b1);
      #2;
      aborts = 1;
      i_rst = 1'b1;
      #1;
      checkOutput("rst_mid_valids", {59'b0, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                  m_axil_bready, m_axil_rready}, 64'd0);
      checkBit("rst_mid_rsp_valid", o_rsp_valid, 1'b0);
      checkOutput("rst_mid_awaddr", {56'b0, m_axil_awaddr}, 64'd0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      @(negedge i_clk);
      checkBit("rst_rel_cmd_ready", o_cmd_ready, 1'b1);
      repeat (12) @(negedge i_clk);
      checkOutput("rst_no_rsp", 64'(rsp_cnt), 64'(base));
      checkOutput("rst_no_b", 64'(b_cnt), 64'd3);
      b_wait = 0;

      r_wait = 0; rdata_cfg = 64'h0123456789ABCDEF; rresp_cfg = 2'b00;
      base = rsp_cnt;
      applyStimulus(1'b0, 8'h30, 64'h0, 8'h00, 64'h0123456789ABCDEF, 2'b00, 1'b1);
      waitRsp(base + 1);
      checkOutput("post_rst_rd_lat", 64'(rsp_rise_cyc - acc_cyc), 64'd3);

      repeat (3) @(negedge i_clk);
      checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 The block SHALL have parameter G_AXIL_ADDR_W, default 8, AXI4-Lite address width.
REQ-002 The block SHALL have parameter G_AXIL_DATA_W, default 64, AXI4-Lite data width (multiple of 8).
REQ-003 The block SHALL have port i_clk  input  1  single clock for all logic.
REQ-004 The block SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port i_cmd_valid  input  1  command request.
REQ-006 The block SHALL have port o_cmd_ready  output  1  block idle, command accepted when both high.
REQ-007 The block SHALL have port i_cmd_wr  input  1  1 = write, 0 = read.
REQ-008 The block SHALL have port i_cmd_addr  input  G_AXIL_ADDR_W  transaction address.
REQ-009 The block SHALL have port i_cmd_wdata  input  G_AXIL_DATA_W  write data.
REQ-010 The block SHALL have port i_cmd_wstrb  input  G_AXIL_DATA_W/8  write byte strobes.
REQ-011 The block SHALL have port o_rsp_valid  output  1  response available.
REQ-012 The block SHALL have port i_rsp_ready  input  1  response consumed when both high.
REQ-013 The block SHALL have port o_rsp_rdata  output  G_AXIL_DATA_W  read data (0 for writes).
REQ-014 The block SHALL have port o_rsp_resp  output  2  captured BRESP or RRESP.
REQ-015 The block SHALL have port m_axil_awvalid  output  1  write address valid.
REQ-016 The block SHALL have port m_axil_awready  input  1  write address ready.
REQ-017 The block SHALL have port m_axil_awaddr  output  G_AXIL_ADDR_W  write address.
REQ-018 The block SHALL have port m_axil_awprot  output  3  constant 3'b000.
REQ-019 The block SHALL have port m_axil_wvalid  output  1  write data valid.
REQ-020 The block SHALL have port m_axil_wready  input  1  write data ready.
REQ-021 The block SHALL have port m_axil_wdata  output  G_AXIL_DATA_W  write data.
REQ-022 The block SHALL have port m_axil_wstrb  output  G_AXIL_DATA_W/8  write strobes.
REQ-023 The block SHALL have port m_axil_bvalid  input  1  write response valid.
REQ-024 The block SHALL have port m_axil_bready  output  1  write response ready.
REQ-025 The block SHALL have port m_axil_bresp  input  2  write response code.
REQ-026 The block SHALL have port m_axil_arvalid  output  1  read address valid.
REQ-027 The block SHALL have port m_axil_arready  input  1  read address ready.
REQ-028 The block SHALL have port m_axil_araddr  output  G_AXIL_ADDR_W  read address.
REQ-029 The block SHALL have port m_axil_arprot  output  3  constant 3'b000.
REQ-030 The block SHALL have port m_axil_rvalid  input  1  read data valid.
REQ-031 The block SHALL have port m_axil_rready  output  1  read data ready.
REQ-032 The block SHALL have port m_axil_rdata  input  G_AXIL_DATA_W  read data.
REQ-033 The block SHALL have port m_axil_rresp  input  2  read response code.

Function
REQ-034 The block SHALL implement FSM IDLE -> (WADDR | RADDR) -> (WRESP | RDATA) -> RSP -> IDLE, one transaction outstanding, all outputs registered.
REQ-035 The block SHALL assert o_cmd_ready only in IDLE; on accept it SHALL latch addr/wdata/wstrb/wr and assert awvalid+wvalid (write) or arvalid (read) the next cycle.
REQ-036 In WADDR, awvalid and wvalid SHALL each drop independently on their own handshake, in either order or the same cycle; address/data/strobes SHALL stay stable while valid.
REQ-037 The block SHALL enter WRESP only after both AW and W handshakes complete, assert bready there only, and on the B handshake capture bresp, set o_rsp_rdata=0, and enter RSP.
REQ-038 In RADDR, arvalid SHALL hold until arready; RDATA SHALL assert rready only there, and on the R handshake capture rdata/rresp and enter RSP.
REQ-039 In RSP, o_rsp_valid SHALL be 1 with o_rsp_rdata/o_rsp_resp stable until i_rsp_ready; then the FSM SHALL return to IDLE with o_cmd_ready=1 the next cycle.
REQ-040 Zero-wait-state latency SHALL be: accept at cycle N, AW/W or AR handshake at N+1, B/R handshake at N+2, o_rsp_valid at N+3.
REQ-041 The block SHALL ignore i_cmd_valid outside IDLE and SHALL ignore a bvalid/rvalid that arrives before the matching address phase completes.

Reset
REQ-042 While i_rst=1, asynchronously: FSM=IDLE, all m_axil valid/ready outputs=0, o_rsp_valid=0, o_cmd_ready=1, data/addr/resp outputs=0; an in-flight transaction SHALL be abandoned with no response.

Verification
REQ-043 Write addr 0x10, data 0x1122334455667788, wstrb 0xFF, slave zero-wait, bresp=0 -> AW/W at N+1, rsp_valid at N+3, resp=0, rdata=0.
REQ-044 Read addr 0x20, slave returns 0xDEADBEEF00000001 with rresp=2'b10 after 5 wait cycles -> rsp_rdata=0xDEADBEEF00000001, resp=2'b10.
REQ-045 Write with wready 3 cycles before awready -> wvalid drops first, awvalid holds, bready rises only after both handshakes.
REQ-046 Hold i_rsp_ready=0 for 4 cycles -> rsp_valid and data stable, o_cmd_ready=0, new i_cmd_valid ignored.
REQ-047 Assert i_rst during WRESP -> all valids/readies 0 immediately, o_cmd_ready=1 after release, next read completes normally.
